// File: rtl/cnt_seq_pkg.sv
// Shared types and default parameters for the counter-sequence checker.
// The FSM state type and the mod-256 step helper live here.
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } seq_state_t;

    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_UNLOCK_ERR = 2;
    localparam int unsigned DEF_ERR_W      = 16;

    // Next value of the free-running source; 0xFF wraps to 0x00.
    function automatic logic [7:0] seq_next(input logic [7:0] v);
        return v + 8'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear has priority over increment, and the count holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side checker for the free-running 8-bit counter source: acquires lock
// on an incrementing mod-256 stream, then flags and counts sequence errors.
module cnt_seq_checker
    import cnt_seq_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned UNLOCK_ERR = DEF_UNLOCK_ERR,
    parameter int unsigned ERR_W      = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [7:0]       sample_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_stb,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       expected
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(UNLOCK_ERR + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_ERR - 1);

    seq_state_t      state, state_nxt;
    logic [7:0]      exp_q, exp_nxt;
    logic [GW-1:0]   good_run, good_nxt;
    logic [MW-1:0]   miss_run, miss_nxt;
    logic            locked_q;
    logic            stb_q, stb_nxt;
    logic            err_inc;
    logic            hit;

    assign hit = (sample_data == exp_q);

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        good_nxt  = good_run;
        miss_nxt  = miss_run;
        stb_nxt   = 1'b0;
        err_inc   = 1'b0;

        if (sample_en) begin
            case (state)
                IDLE: begin
                    exp_nxt   = seq_next(sample_data);
                    good_nxt  = '0;
                    state_nxt = ACQ;
                end
                ACQ: begin
                    exp_nxt = seq_next(sample_data);
                    if (hit) begin
                        good_nxt = good_run + GW'(1);
                        if (good_run == GOOD_LAST) begin
                            state_nxt = LOCK;
                            miss_nxt  = '0;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCK: begin
                    if (hit) begin
                        miss_nxt = '0;
                        exp_nxt  = seq_next(sample_data);
                    end else begin
                        stb_nxt = 1'b1;
                        err_inc = 1'b1;
                        // Flywheel through isolated misses; resync on the data once lock drops.
                        if (miss_run == MISS_LAST) begin
                            state_nxt = ACQ;
                            exp_nxt   = seq_next(sample_data);
                            good_nxt  = '0;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss_run + MW'(1);
                            exp_nxt  = seq_next(exp_q);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            exp_q    <= '0;
            good_run <= '0;
            miss_run <= '0;
            locked_q <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            exp_q    <= exp_nxt;
            good_run <= good_nxt;
            miss_run <= miss_nxt;
            locked_q <= (state_nxt == LOCK);
            stb_q    <= stb_nxt;
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (err_inc),
        .count(err_count)
    );

    assign locked   = locked_q;
    assign err_stb  = stb_q;
    assign expected = exp_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Self-checking bench: directed scenarios plus a randomized counter stream, both
// scored against an integer-level model of the lock/flywheel rules.
module tb_cnt_seq_checker;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_ERR = 2;

    logic        clk;
    logic        rst;
    logic        sample_en;
    logic [7:0]  sample_data;
    logic        clear;
    logic        locked, locked_w2;
    logic        err_stb, err_stb_w2;
    logic [15:0] err_count;
    logic [1:0]  err_count_w2;
    logic [7:0]  expected, expected_w2;

    int n_vec = 0;
    int n_mis = 0;

    // Model state: whether a reference sample has been seen, lock flag, run lengths.
    bit m_seen, m_locked, m_stb;
    int m_exp, m_good, m_miss, m_err16, m_err2;

    cnt_seq_checker dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .sample_data(sample_data),
        .clear      (clear),
        .locked     (locked),
        .err_stb    (err_stb),
        .err_count  (err_count),
        .expected   (expected)
    );

    cnt_seq_checker #(
        .ERR_W(2)
    ) dut_w2 (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .sample_data(sample_data),
        .clear      (clear),
        .locked     (locked_w2),
        .err_stb    (err_stb_w2),
        .err_count  (err_count_w2),
        .expected   (expected_w2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit en, input int d, input bit clr, input bit r);
        if (r) begin
            m_seen = 0; m_locked = 0; m_stb = 0;
            m_exp = 0; m_good = 0; m_miss = 0; m_err16 = 0; m_err2 = 0;
            return;
        end
        m_stb = 0;
        if (en) begin
            if (!m_seen) begin
                m_seen = 1;
                m_exp  = (d + 1) % 256;
                m_good = 0;
            end else if (!m_locked) begin
                if (d == m_exp) begin
                    m_good++;
                    if (m_good >= LOCK_CNT) begin
                        m_locked = 1;
                        m_miss   = 0;
                    end
                end else begin
                    m_good = 0;
                end
                m_exp = (d + 1) % 256;
            end else if (d == m_exp) begin
                m_miss = 0;
                m_exp  = (d + 1) % 256;
            end else begin
                m_stb = 1;
                if (m_err16 < 65535) m_err16++;
                if (m_err2 < 3) m_err2++;
                m_miss++;
                m_exp = (m_exp + 1) % 256;
                if (m_miss >= UNLOCK_ERR) begin
                    m_locked = 0;
                    m_exp    = (d + 1) % 256;
                    m_good   = 0;
                    m_miss   = 0;
                end
            end
        end
        if (clr) begin
            m_err16 = 0;
            m_err2  = 0;
        end
    endtask

    task automatic compare_all();
        check_eq("locked",       32'(locked),       32'(m_locked));
        check_eq("err_stb",      32'(err_stb),      32'(m_stb));
        check_eq("expected",     32'(expected),     32'(m_exp));
        check_eq("err_count",    32'(err_count),    32'(m_err16));
        check_eq("err_stb_w2",   32'(err_stb_w2),   32'(m_stb));
        check_eq("err_count_w2", 32'(err_count_w2), 32'(m_err2));
    endtask

    task automatic step(input bit en, input logic [7:0] d, input bit clr, input bit r);
        @(negedge clk);
        rst         = r;
        sample_en   = en;
        sample_data = d;
        clear       = clr;
        @(posedge clk);
        model_step(en, int'(d), clr, r);
        #1;
        compare_all();
    endtask

    task automatic lock_at(input logic [7:0] s);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(s + 8'(i)), 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] glitch_seq [5];
        logic [7:0] src;
        logic [7:0] bad;
        bit r, en, clr;

        rst = 1'b1; sample_en = 1'b0; sample_data = '0; clear = 1'b0;

        // Reset values
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("rst_locked",   32'(locked),    32'h0);
        check_eq("rst_expected", 32'(expected),  32'h0);
        check_eq("rst_errcnt",   32'(err_count), 32'h0);

        // Lock on 10..14
        lock_at(8'h10);
        check_eq("lock_locked",   32'(locked),    32'h1);
        check_eq("lock_expected", 32'(expected),  32'h15);
        check_eq("lock_errcnt",   32'(err_count), 32'h0);

        // Wrap FD..01
        lock_at(8'hF8);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hFD + 8'(i)), 1'b0, 1'b0);
        check_eq("wrap_locked",   32'(locked),   32'h1);
        check_eq("wrap_expected", 32'(expected), 32'h02);

        // Single glitch
        lock_at(8'h1B);
        glitch_seq = '{8'h20, 8'h21, 8'hAA, 8'h23, 8'h24};
        for (int i = 0; i < 5; i++) step(1'b1, glitch_seq[i], 1'b0, 1'b0);
        check_eq("glitch_errcnt",   32'(err_count), 32'h1);
        check_eq("glitch_locked",   32'(locked),    32'h1);
        check_eq("glitch_expected", 32'(expected),  32'h25);

        // Unlock then relock
        lock_at(8'h3B);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check_eq("unlock_errcnt",   32'(err_count), 32'h2);
        check_eq("unlock_locked",   32'(locked),    32'h0);
        check_eq("unlock_expected", 32'(expected),  32'h78);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h78 + 8'(i)), 1'b0, 1'b0);
        check_eq("relock_locked", 32'(locked), 32'h1);

        // Gap of 10 idle cycles between 50 and 51
        lock_at(8'h4B);
        step(1'b1, 8'h50, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h51, 1'b0, 1'b0);
        check_eq("gap_expected", 32'(expected),  32'h52);
        check_eq("gap_errcnt",   32'(err_count), 32'h0);
        check_eq("gap_locked",   32'(locked),    32'h1);

        // Saturation: five isolated errors, each followed by a matching sample
        lock_at(8'h60);
        for (int k = 0; k < 5; k++) begin
            bad = 8'(m_exp) ^ 8'h80;
            step(1'b1, bad, 1'b0, 1'b0);
            step(1'b1, 8'(m_exp), 1'b0, 1'b0);
        end
        check_eq("sat_errcnt_w2", 32'(err_count_w2), 32'h3);
        check_eq("sat_errcnt",    32'(err_count),    32'h5);
        check_eq("sat_locked",    32'(locked),       32'h1);

        // Clear coinciding with an error
        bad = 8'(m_exp) ^ 8'h80;
        step(1'b1, bad, 1'b1, 1'b0);
        check_eq("clr_stb",       32'(err_stb),      32'h1);
        check_eq("clr_errcnt",    32'(err_count),    32'h0);
        check_eq("clr_errcnt_w2", 32'(err_count_w2), 32'h0);

        // Reset while acquiring; next sample must act as a fresh reference
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h30, 1'b0, 1'b0);
        step(1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("acqrst_locked",   32'(locked),   32'h0);
        check_eq("acqrst_expected", 32'(expected), 32'h00);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("acqrst_ref", 32'(expected), 32'h34);

        // Randomized stream: mostly incrementing, with glitches, jumps, gaps, clears, resets
        src = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) src = 8'($urandom);
            if (en && $urandom_range(0, 11) == 0) begin
                step(en, 8'($urandom), clr, r);
            end else begin
                step(en, src, clr, r);
            end
            if (en) src = src + 8'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
